// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant/split signal bundle between two bus masters,
//               the addressed slave and the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
  logic m1_req;
  logic m2_req;
  logic trans_done;
  logic slave_split;
  logic split_resume;
  logic m1_grant;
  logic m2_grant;
  logic m1_split;
  logic m2_split;
  logic timeout_err;
  logic split_err;

  // Master side: the masters and the addressed slave drive requests and events
  modport master (
    output m1_req, m2_req, trans_done, slave_split, split_resume,
    input  m1_grant, m2_grant, m1_split, m2_split, timeout_err, split_err
  );

  // Slave side: the arbiter consumes requests/events and drives grants/status
  modport slave (
    input  m1_req, m2_req, trans_done, slave_split, split_resume,
    output m1_grant, m2_grant, m1_split, m2_split, timeout_err, split_err
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master bus arbiter with round-robin tie break, split
//               transaction parking/resume and a grant-hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int HOLD_MAX = 1023
) (
  input  wire           clock,
  input  wire           rst,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    TURN     = 2'd3
  } state_t;

  // Timeout fires in the last allowed granted cycle (counter starts at 0)
  localparam logic [9:0] c_hold_last = 10'(HOLD_MAX - 1);

  state_t     r_state,          w_state_nxt;
  logic       r_m1_grant,       w_m1_grant_nxt;
  logic       r_m2_grant,       w_m2_grant_nxt;
  logic       r_m1_split,       w_m1_split_nxt;
  logic       r_m2_split,       w_m2_split_nxt;
  logic       r_resume_pending, w_resume_nxt;
  logic       r_resuming,       w_resuming_nxt;
  logic       r_last_m2,        w_last_m2_nxt;
  logic [9:0] r_hold_cnt,       w_cnt_nxt;
  logic       r_timeout_err,    w_timeout_nxt;
  logic       r_split_err,      w_split_err_nxt;

  logic w_split_pending;
  logic w_m1_elig;
  logic w_m2_elig;
  logic w_owner_m2;
  logic w_owner_req;

  assign w_split_pending = r_m1_split | r_m2_split;
  assign w_m1_elig       = bus.m1_req & ~r_m1_split;
  assign w_m2_elig       = bus.m2_req & ~r_m2_split;
  assign w_owner_m2      = (r_state == GRANT_M2);
  assign w_owner_req     = w_owner_m2 ? bus.m2_req : bus.m1_req;

  // State register and all registered outputs/flags
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state          <= IDLE;
      r_m1_grant       <= 1'b0;
      r_m2_grant       <= 1'b0;
      r_m1_split       <= 1'b0;
      r_m2_split       <= 1'b0;
      r_resume_pending <= 1'b0;
      r_resuming       <= 1'b0;
      r_last_m2        <= 1'b1;
      r_hold_cnt       <= 10'd0;
      r_timeout_err    <= 1'b0;
      r_split_err      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_m1_grant       <= w_m1_grant_nxt;
      r_m2_grant       <= w_m2_grant_nxt;
      r_m1_split       <= w_m1_split_nxt;
      r_m2_split       <= w_m2_split_nxt;
      r_resume_pending <= w_resume_nxt;
      r_resuming       <= w_resuming_nxt;
      r_last_m2        <= w_last_m2_nxt;
      r_hold_cnt       <= w_cnt_nxt;
      r_timeout_err    <= w_timeout_nxt;
      r_split_err      <= w_split_err_nxt;
    end
  end

  // Next-state, grant selection, split bookkeeping and hold timer
  always_comb begin
    w_state_nxt     = r_state;
    w_m1_grant_nxt  = 1'b0;
    w_m2_grant_nxt  = 1'b0;
    w_m1_split_nxt  = r_m1_split;
    w_m2_split_nxt  = r_m2_split;
    w_resume_nxt    = r_resume_pending;
    w_resuming_nxt  = r_resuming;
    w_last_m2_nxt   = r_last_m2;
    w_cnt_nxt       = r_hold_cnt;
    w_timeout_nxt   = 1'b0;
    w_split_err_nxt = 1'b0;

    // A resume is only meaningful while some master is parked
    if (bus.split_resume && w_split_pending) begin
      w_resume_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (r_resume_pending) begin
          // Parked master returns first; its flags clear as the grant rises
          w_resume_nxt   = 1'b0;
          w_resuming_nxt = 1'b1;
          w_cnt_nxt      = 10'd0;
          if (r_m1_split) begin
            w_state_nxt    = GRANT_M1;
            w_m1_grant_nxt = 1'b1;
            w_m1_split_nxt = 1'b0;
            w_last_m2_nxt  = 1'b0;
          end else begin
            w_state_nxt    = GRANT_M2;
            w_m2_grant_nxt = 1'b1;
            w_m2_split_nxt = 1'b0;
            w_last_m2_nxt  = 1'b1;
          end
        end else if (w_m1_elig && (!w_m2_elig || r_last_m2)) begin
          w_state_nxt    = GRANT_M1;
          w_m1_grant_nxt = 1'b1;
          w_last_m2_nxt  = 1'b0;
          w_resuming_nxt = 1'b0;
          w_cnt_nxt      = 10'd0;
        end else if (w_m2_elig) begin
          w_state_nxt    = GRANT_M2;
          w_m2_grant_nxt = 1'b1;
          w_last_m2_nxt  = 1'b1;
          w_resuming_nxt = 1'b0;
          w_cnt_nxt      = 10'd0;
        end
      end

      GRANT_M1, GRANT_M2: begin
        // Any end event moves to TURN; grant falls on the following edge
        w_state_nxt    = TURN;
        w_resuming_nxt = 1'b0;
        if (bus.slave_split) begin
          if (w_split_pending) begin
            // Only one split may be outstanding: reject and end the transfer
            w_split_err_nxt = 1'b1;
          end else if (w_owner_m2) begin
            w_m2_split_nxt = 1'b1;
          end else begin
            w_m1_split_nxt = 1'b1;
          end
        end else if (bus.trans_done) begin
          w_state_nxt = TURN;
        end else if (!r_resuming && !w_owner_req) begin
          w_state_nxt = TURN;
        end else if (r_hold_cnt == c_hold_last) begin
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt    = r_state;
          w_resuming_nxt = r_resuming;
          w_m1_grant_nxt = ~w_owner_m2;
          w_m2_grant_nxt = w_owner_m2;
          w_cnt_nxt      = r_hold_cnt + 10'd1;
        end
      end

      TURN: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.m1_grant    = r_m1_grant;
  assign bus.m2_grant    = r_m2_grant;
  assign bus.m1_split    = r_m1_split;
  assign bus.m2_split    = r_m2_split;
  assign bus.timeout_err = r_timeout_err;
  assign bus.split_err   = r_split_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter (HOLD_MAX = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic clock;
  logic rst;
  int   n_checks;
  int   n_errors;

  bus_arbiter_if bus ();

  bus_arbiter #(.HOLD_MAX(8)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    chk("mutex", 8'(bus.m1_grant & bus.m2_grant), 8'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    bus.m1_req       = 1'b0;
    bus.m2_req       = 1'b0;
    bus.trans_done   = 1'b0;
    bus.slave_split  = 1'b0;
    bus.split_resume = 1'b0;
    tick();
    tick();
    chk("reset_outs", 8'({bus.m1_grant, bus.m2_grant, bus.m1_split, bus.m2_split,
                          bus.timeout_err, bus.split_err}), 8'd0);

    // Tie after reset: M1 first, then M2 two cycles after M1's release edge
    rst = 1'b0; bus.m1_req = 1'b1; bus.m2_req = 1'b1;
    tick();
    chk("tie_m1_grant", 8'(bus.m1_grant), 8'd1);
    chk("tie_m2_wait", 8'(bus.m2_grant), 8'd0);
    bus.trans_done = 1'b1;
    tick();
    bus.trans_done = 1'b0; bus.m1_req = 1'b0;
    chk("turn_no_grant", 8'({bus.m1_grant, bus.m2_grant}), 8'd0);
    tick();
    chk("idle_no_grant", 8'({bus.m1_grant, bus.m2_grant}), 8'd0);
    tick();
    chk("rr_m2_grant", 8'(bus.m2_grant), 8'd1);
    bus.trans_done = 1'b1; bus.m2_req = 1'b0;
    tick();
    bus.trans_done = 1'b0;
    tick();

    // M1 alone, regranted with a 2-cycle gap each time
    bus.m1_req = 1'b1;
    tick();
    chk("solo_first", 8'({bus.m1_grant, bus.m2_grant}), 8'b10);
    for (int i = 0; i < 3; i++) begin
      bus.trans_done = 1'b1;
      tick();
      bus.trans_done = 1'b0;
      chk("solo_gap1", 8'(bus.m1_grant), 8'd0);
      tick();
      chk("solo_gap2", 8'(bus.m1_grant), 8'd0);
      tick();
      chk("solo_regrant", 8'({bus.m1_grant, bus.m2_grant}), 8'b10);
    end
    bus.trans_done = 1'b1; bus.m1_req = 1'b0;
    tick();
    bus.trans_done = 1'b0;
    tick();

    // Split M1, grant M2, resume M1 after M2 completes
    bus.m1_req = 1'b1;
    tick();
    chk("sp_m1_grant", 8'(bus.m1_grant), 8'd1);
    bus.slave_split = 1'b1; bus.m2_req = 1'b1;
    tick();
    bus.slave_split = 1'b0; bus.m1_req = 1'b0;
    chk("sp_m1_parked", 8'({bus.m1_grant, bus.m1_split}), 8'b01);
    tick();
    tick();
    chk("sp_m2_grant", 8'(bus.m2_grant), 8'd1);
    bus.split_resume = 1'b1;
    tick();
    bus.split_resume = 1'b0;
    chk("sp_no_preempt", 8'({bus.m1_grant, bus.m2_grant}), 8'b01);
    bus.trans_done = 1'b1;
    tick();
    bus.trans_done = 1'b0;
    tick();
    tick();
    chk("resume_grant", 8'({bus.m1_grant, bus.m1_split, bus.m2_grant}), 8'b100);
    tick();
    chk("resume_req_ignored", 8'(bus.m1_grant), 8'd1);
    bus.trans_done = 1'b1; bus.m2_req = 1'b0; bus.m1_req = 1'b1;
    tick();
    bus.trans_done = 1'b0;
    tick();
    tick();
    chk("m1_again", 8'(bus.m1_grant), 8'd1);

    // Second split while M1 parked is rejected
    bus.slave_split = 1'b1; bus.m2_req = 1'b1;
    tick();
    bus.slave_split = 1'b0; bus.m1_req = 1'b0;
    tick();
    tick();
    chk("sp2_m2_grant", 8'(bus.m2_grant), 8'd1);
    bus.slave_split = 1'b1;
    tick();
    bus.slave_split = 1'b0;
    chk("sp2_err", 8'({bus.split_err, bus.m2_split, bus.m2_grant, bus.m1_split}), 8'b1001);
    tick();
    chk("sp2_err_pulse", 8'(bus.split_err), 8'd0);
    tick();
    chk("sp2_m2_regrant", 8'({bus.m2_grant, bus.m1_split}), 8'b11);

    // Reset mid-transaction with M1 parked
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", 8'({bus.m1_grant, bus.m2_grant, bus.m1_split, bus.m2_split,
                            bus.timeout_err, bus.split_err}), 8'd0);
    rst = 1'b0; bus.m2_req = 1'b0; bus.m1_req = 1'b1;
    tick();
    chk("rst_m1_grant", 8'(bus.m1_grant), 8'd1);

    // Timeout: grant held for exactly 8 cycles, then forced release
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_hold", 8'({bus.m1_grant, bus.timeout_err}), 8'b10);
    end
    tick();
    chk("to_release", 8'({bus.m1_grant, bus.timeout_err}), 8'b01);
    tick();
    chk("to_pulse", 8'(bus.timeout_err), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, 1023, maximum grant-hold cycles before forced release (range 1..1023, 10-bit counter).
REQ-002 Port: clock  in  1  sole clock; all logic updates on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: m1_req  in  1  Master 1 bus request; level, held until grant or abandoned.
REQ-005 Port: m2_req  in  1  Master 2 bus request; same rules as m1_req.
REQ-006 Port: trans_done  in  1  one-cycle pulse from the granted master when its transaction (single or burst) ends.
REQ-007 Port: slave_split  in  1  one-cycle pulse from the addressed slave splitting the current transaction.
REQ-008 Port: split_resume  in  1  one-cycle pulse from the split slave when it is ready to complete.
REQ-009 Port: m1_grant  out  1  Master 1 owns the bus.
REQ-010 Port: m2_grant  out  1  Master 2 owns the bus.
REQ-011 Port: m1_split  out  1  Master 1 is parked on a split.
REQ-012 Port: m2_split  out  1  Master 2 is parked on a split.
REQ-013 Port: timeout_err  out  1  one-cycle pulse when a grant is force-released.
REQ-014 Port: split_err  out  1  one-cycle pulse when a split is rejected.

Function
REQ-015 FSM states: IDLE, GRANT_M1, GRANT_M2, TURN. All outputs are registered.
REQ-016 IDLE, eligible request present: grant is asserted the next cycle, giving 1-cycle request-to-grant latency.
- A master is eligible when its req=1 and its split flag=0.
- Exception: a parked master whose split_resume has been latched is eligible without a request.
REQ-017 Priority order:
- A resumed split master first.
- Otherwise, both eligible: round-robin, the master not granted last wins.
- Otherwise, the single eligible master wins.
REQ-018 m1_grant and m2_grant are mutually exclusive in every cycle.
REQ-019 GRANT_x holds until trans_done, slave_split, timeout, or the owner's req dropping, then enters TURN.
- Grant deasserts on the cycle after the event.
- Holding-master req is ignored while the master is resuming a split.
REQ-020 TURN lasts exactly one cycle with no grant, then goes to IDLE. Minimum gap between two grants is 2 cycles.
REQ-021 slave_split in GRANT_x with no split pending: set mx_split=1 and release the grant.
REQ-022 slave_split while a split is already pending: treat as trans_done, pulse split_err, and set no new split flag.
REQ-023 slave_split and trans_done in the same cycle: slave_split wins.
REQ-024 split_resume is latched in a resume_pending flag.
- No pre-emption: a current owner completes first.
- On granting the resumed master, clear mx_split and resume_pending in the same cycle the grant rises.
REQ-025 split_resume with no split pending is ignored and sets no flag.
REQ-026 Hold counter:
- Clears on grant entry and increments each granted cycle.
- When the count reaches HOLD_MAX without an end event, pulse timeout_err and release.
- A timed-out split-resume also clears its split flag.
REQ-027 slave_split, trans_done and split_resume are ignored in IDLE and TURN, except that split_resume is still latched.
REQ-028 Last-granted register updates on every grant rise.

Reset
REQ-029 With rst=1 at a rising edge, on the next edge:
- State goes to IDLE.
- All outputs become 0.
- Split flags, resume_pending and the counter clear.
- Last-granted becomes M2, so M1 wins the first tie.
REQ-030 Reset mid-transaction drops the grant immediately on that edge, with no TURN cycle. Outstanding splits are discarded.

Verification
REQ-031 The bench covers these directed scenarios:
- Reset release, m1_req=m2_req=1 -> m1_grant=1 after 1 cycle. After trans_done, TURN, then m2_grant=1 2 cycles after the release edge.
- Only m1_req repeatedly, trans_done each time -> M1 regranted each time with a 2-cycle gap, and m2_grant stays 0.
- M1 granted, slave_split -> m1_split=1 and m1_grant=0. M2 request granted. split_resume during M2 ownership, M2 trans_done -> m1_grant=1 and m1_split=0, while M2 is not regranted even though it still requests.
- Second slave_split from M2 while M1 is parked -> split_err pulse for 1 cycle, m2_split stays 0, and M2 is released.
- HOLD_MAX=8, M1 granted, no trans_done -> timeout_err pulse with grant dropped after 8 granted cycles.
- rst=1 while m2_grant=1 and m1_split=1 -> next edge gives all outputs 0. After release with m1_req=1, m1_grant=1 after 1 cycle.
